// File: rtl/spi_screen_tx.sv
// spi_screen_tx: mode-0 (CPOL=0, CPHA=0) MSB-first SPI master serializer for the static-screen path.
// Ports: sck system clock, rst_in sync active-high reset, start_spi/data_in/dc_in request a frame in IDLE;
// spi_done high when idle or frame complete; spi_clk/spi_mosi/spi_cs_n/spi_dc are registered SPI outputs.
module spi_screen_tx #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              sck,
  input  logic              rst_in,
  input  logic              start_spi,
  input  logic [DATA_W-1:0] data_in,
  input  logic              dc_in,
  output logic              spi_done,
  output logic              spi_clk,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              spi_dc
);
  localparam int BW = $clog2(DATA_W);
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;
  state_t state_q, state_d;
  logic [7:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  // The MSB goes straight to spi_mosi on accept, so only the remaining bits are stored.
  logic [DATA_W-2:0] rest_q, rest_d;
  logic mosi_q, mosi_d, dc_q, dc_d, clk_q, clk_d, cs_n_q, cs_n_d, done_q, done_d;
  logic phase_end, accept, shift;
  assign phase_end = div_q == DIV_LAST;
  assign accept = state_q == IDLE && start_spi;
  assign shift = state_q == HIGH && phase_end && bit_q != BIT_LAST;
  always_ff @(posedge sck) state_q <= rst_in ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      state_d = start_spi ? LEAD : IDLE;
      LEAD, LOW: state_d = phase_end ? HIGH : state_q;
      HIGH:      state_d = !phase_end ? HIGH : bit_q == BIT_LAST ? TRAIL : LOW;
      TRAIL:     state_d = phase_end ? IDLE : TRAIL;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    div_d  = (state_q == IDLE || phase_end) ? '0 : div_q + 8'd1;
    rest_d = accept ? data_in[DATA_W-2:0] : shift ? rest_q << 1 : rest_q;
    bit_d  = accept ? '0 : shift ? bit_q + 1'b1 : bit_q;
    mosi_d = accept ? data_in[DATA_W-1] : shift ? rest_q[DATA_W-2] :
             (state_q == TRAIL && phase_end) ? 1'b0 : mosi_q;
    dc_d   = accept ? dc_in : dc_q;
    clk_d  = state_d == HIGH;
    cs_n_d = state_d == IDLE;
    done_d = state_d == IDLE;
  end
  always_ff @(posedge sck) begin
    if (rst_in) begin
      div_q  <= '0;
      bit_q  <= '0;
      rest_q <= '0;
      mosi_q <= 1'b0;
      dc_q   <= 1'b0;
      clk_q  <= 1'b0;
      cs_n_q <= 1'b1;
      done_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      rest_q <= rest_d;
      mosi_q <= mosi_d;
      dc_q   <= dc_d;
      clk_q  <= clk_d;
      cs_n_q <= cs_n_d;
      done_q <= done_d;
    end
  end
  assign spi_done = done_q;
  assign spi_clk  = clk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;
  assign spi_dc   = dc_q;
endmodule
